game_state_ctrl: RTL and testbench
==================================

GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

Interface
REQ-001 Parameter c_START_LIVES, 3, lives loaded on game start (1..3).
REQ-002 Parameter c_DEATH_CYCLES, 25000000, DYING duration in clocks (>=2).
REQ-003 Parameter c_FLASH_DIV, 3125000, clocks per o_Death_Flash half-period.
REQ-004 Parameter c_PADS_PER_LEVEL, 5, score increments per level step.
REQ-005 Parameter c_WIN_SCORE, 20, score that ends the game as won (<=127).
REQ-006 i_Clk  in  1  system clock; all logic on rising edge.
REQ-007 i_Rst_L  in  1  asynchronous active-low reset.
REQ-008 i_Start  in  1  start switch level, asynchronous to i_Clk.
REQ-009 i_Collided  in  1  road collision, sampled each clock.
REQ-010 i_Drowned  in  1  water-without-log condition, sampled each clock.
REQ-011 i_Score  in  7  current score from frog control.
REQ-012 o_Game_Active  out  1  high only in PLAYING; gates frog control.
REQ-013 o_State  out  3  encoded FSM state.
REQ-014 o_Lives  out  2  remaining lives.
REQ-015 o_Level  out  3  difficulty level for lane speed, saturating at 7.
REQ-016 o_Death_Flash  out  1  blink for frog sprite during DYING, else 0.
REQ-017 o_Score_Clr  out  1  one-cycle pulse requesting score clear.

Function
REQ-018 States SHALL be IDLE=0, PLAYING=1, DYING=2, GAME_OVER=3, WIN=4; encodings 5-7 SHALL return to IDLE next cycle.
REQ-019 i_Start SHALL be 2-flop synchronised; a start event is a 0->1 edge of the synchronised signal (2-3 cycles latency).
REQ-020 IDLE + start event -> PLAYING; same edge: o_Lives=c_START_LIVES, o_Level=0, death counter=0, o_Score_Clr=1 for exactly that one cycle.
REQ-021 PLAYING + (i_Collided or i_Drowned) at edge N -> DYING at N+1, with o_Lives decremented and o_Game_Active=0 at N+1.
REQ-022 PLAYING + i_Score>=c_WIN_SCORE -> WIN; WIN SHALL take priority over a simultaneous hit, and lives SHALL stay unchanged.
REQ-023 DYING: counter increments each clock; on reaching c_DEATH_CYCLES-1 -> GAME_OVER if o_Lives==0, else PLAYING; counter clears on exit.
REQ-024 Hits and start events in DYING, GAME_OVER and WIN SHALL be ignored; start events in PLAYING and DYING SHALL be ignored.
REQ-025 GAME_OVER or WIN + start event -> IDLE; a second start event is needed to play.
REQ-026 o_Level SHALL be registered as min(i_Score / c_PADS_PER_LEVEL, 7); it updates one clock after i_Score changes and only in PLAYING.
REQ-027 o_Death_Flash SHALL toggle every c_FLASH_DIV clocks in DYING, start at 1 on DYING entry, and be 0 in all other states.
REQ-028 o_Lives SHALL never underflow; decrement occurs only on PLAYING->DYING, and lives==1 becomes 0.
REQ-029 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-030 i_Rst_L low SHALL asynchronously force IDLE, o_Game_Active=0, o_Lives=0, o_Level=0, o_Death_Flash=0, o_Score_Clr=0, and clear all counters and synchronisers.
REQ-031 Reset asserted mid-DYING or mid-PLAYING SHALL discard the remaining count; after release the block waits in IDLE for a start event.

Structure
REQ-032 Package frogger_pkg SHALL hold the state encodings, c_START_LIVES, c_WIN_SCORE, c_PADS_PER_LEVEL and the clock frequency constant.
REQ-033 Sub-module btn_edge_sync (2-flop synchroniser plus rising-edge pulse, async active-low reset) SHALL implement REQ-019.
REQ-034 The death counter SHALL be 25 bits wide for default parameters, and the flash divider 22 bits wide.

Verification (c_DEATH_CYCLES=8, c_FLASH_DIV=2)
REQ-035 Reset release, then pulse i_Start -> PLAYING within 3 cycles; o_Lives=3, o_Score_Clr high exactly 1 cycle, o_Game_Active=1.
REQ-036 i_Collided high 1 cycle in PLAYING -> next cycle o_State=2, o_Lives=2, o_Game_Active=0; after 8 cycles o_State=1; o_Death_Flash pattern 1,1,0,0,1,1,0,0.
REQ-037 Three hits with i_Drowned held high through DYING -> o_Lives=0 and GAME_OVER (no further decrement); start -> IDLE; start -> PLAYING with o_Lives=3.
REQ-038 i_Score=20 with i_Collided=1 on the same cycle -> WIN, o_Lives unchanged; i_Score sweep 0..45 -> o_Level=0,1,...,7 and held at 7.
REQ-039 i_Rst_L low at DYING cycle 4 -> immediate IDLE with all outputs 0; no transition after release until a start event.
REQ-040 i_Start toggled during PLAYING and DYING -> no state change; bounce shorter than 1 clock -> at most one start event.

Source files
------------

// File: rtl/frogger_pkg.sv
// Shared constants, state encoding and level helper for the frogger game controller.
package frogger_pkg;

    localparam int c_CLK_FREQ_HZ    = 25_000_000;
    localparam int c_START_LIVES    = 3;
    localparam int c_WIN_SCORE      = 20;
    localparam int c_PADS_PER_LEVEL = 5;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLAYING   = 3'd1,
        ST_DYING     = 3'd2,
        ST_GAME_OVER = 3'd3,
        ST_WIN       = 3'd4
    } state_t;

    // Difficulty level from score, saturating at the top lane speed.
    function automatic logic [2:0] level_of(input logic [6:0] score, input int pads);
        int q;
        q = int'(score) / pads;
        return (q > 7) ? 3'd7 : 3'(q);
    endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchroniser for an asynchronous level, plus a one-cycle rising-edge pulse.
module btn_edge_sync
    import frogger_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic meta;
    logic sync;
    logic sync_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            meta   <= din;
            sync   <= meta;
            sync_d <= sync;
        end
    end

    assign rise = sync & ~sync_d;

endmodule

// File: rtl/game_state_ctrl.sv
// Frogger game flow controller: start/play/death/game-over/win sequencing,
// lives and level bookkeeping, and the death-blink for the frog sprite.
module game_state_ctrl #(
    parameter int c_START_LIVES    = frogger_pkg::c_START_LIVES,
    parameter int c_DEATH_CYCLES   = frogger_pkg::c_CLK_FREQ_HZ,
    parameter int c_FLASH_DIV      = frogger_pkg::c_CLK_FREQ_HZ / 8,
    parameter int c_PADS_PER_LEVEL = frogger_pkg::c_PADS_PER_LEVEL,
    parameter int c_WIN_SCORE      = frogger_pkg::c_WIN_SCORE
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Start,
    input  logic       i_Collided,
    input  logic       i_Drowned,
    input  logic [6:0] i_Score,
    output logic       o_Game_Active,
    output logic [2:0] o_State,
    output logic [1:0] o_Lives,
    output logic [2:0] o_Level,
    output logic       o_Death_Flash,
    output logic       o_Score_Clr
);
    import frogger_pkg::*;

    localparam int DW = $clog2(c_DEATH_CYCLES);
    localparam int FW = (c_FLASH_DIV > 1) ? $clog2(c_FLASH_DIV) : 1;
    localparam logic [DW-1:0] DEATH_LAST = DW'(c_DEATH_CYCLES - 1);
    localparam logic [FW-1:0] FLASH_LAST = FW'(c_FLASH_DIV - 1);

    state_t        state;
    state_t        next_state;
    logic          start_evt;
    logic          hit;
    logic          win;
    logic          death_done;
    logic [DW-1:0] death_cnt;
    logic [FW-1:0] flash_cnt;
    logic [1:0]    lives_nxt;
    logic [2:0]    level_nxt;
    logic          active_nxt;
    logic          clr_nxt;

    btn_edge_sync u_start_sync (
        .clk   (i_Clk),
        .rst_n (i_Rst_L),
        .din   (i_Start),
        .rise  (start_evt)
    );

    assign hit        = i_Collided | i_Drowned;
    assign win        = (int'(i_Score) >= c_WIN_SCORE);
    assign death_done = (death_cnt == DEATH_LAST);
    assign o_State    = state;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Win beats a same-cycle hit; start events only matter in IDLE, GAME_OVER and WIN.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:      if (start_evt) next_state = ST_PLAYING;
            ST_PLAYING: begin
                if (win)      next_state = ST_WIN;
                else if (hit) next_state = ST_DYING;
            end
            ST_DYING:     if (death_done) next_state = (o_Lives == 2'd0) ? ST_GAME_OVER : ST_PLAYING;
            ST_GAME_OVER: if (start_evt) next_state = ST_IDLE;
            ST_WIN:       if (start_evt) next_state = ST_IDLE;
            default:      next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        lives_nxt  = o_Lives;
        level_nxt  = o_Level;
        clr_nxt    = 1'b0;
        active_nxt = (next_state == ST_PLAYING);
        if (state == ST_IDLE && start_evt) begin
            lives_nxt = 2'(c_START_LIVES);
            level_nxt = 3'd0;
            clr_nxt   = 1'b1;
        end
        if (state == ST_PLAYING) begin
            level_nxt = level_of(i_Score, c_PADS_PER_LEVEL);
            if (next_state == ST_DYING && o_Lives != 2'd0) begin
                lives_nxt = o_Lives - 2'd1;
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_Lives       <= 2'd0;
            o_Level       <= 3'd0;
            o_Game_Active <= 1'b0;
            o_Score_Clr   <= 1'b0;
            o_Death_Flash <= 1'b0;
            death_cnt     <= '0;
            flash_cnt     <= '0;
        end else begin
            o_Lives       <= lives_nxt;
            o_Level       <= level_nxt;
            o_Game_Active <= active_nxt;
            o_Score_Clr   <= clr_nxt;
            // Counters only run while staying in DYING; blink starts lit on entry.
            if (state == ST_DYING && next_state == ST_DYING) begin
                death_cnt <= death_cnt + 1'b1;
                if (flash_cnt == FLASH_LAST) begin
                    flash_cnt     <= '0;
                    o_Death_Flash <= ~o_Death_Flash;
                end else begin
                    flash_cnt <= flash_cnt + 1'b1;
                end
            end else begin
                death_cnt     <= '0;
                flash_cnt     <= '0;
                o_Death_Flash <= (next_state == ST_DYING);
            end
        end
    end

endmodule

// File: tb/tb_game_state_ctrl.sv
// Bench for game_state_ctrl: vector table, directed corner sequences, and random run against a model.
module tb_game_state_ctrl;

    localparam int DEATH = 8;
    localparam int FDIV  = 2;
    localparam int PADS  = 5;
    localparam int WINSC = 20;
    localparam int LIVES = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       collided;
    logic       drowned;
    logic [6:0] score;
    logic [6:0] score2;

    logic       active,  active2;
    logic [2:0] state,   state2;
    logic [1:0] lives,   lives2;
    logic [2:0] level,   level2;
    logic       flash,   flash2;
    logic       clr,     clr2;

    logic [10:0] outs;
    assign outs = {state, lives, level, active, flash, clr};

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    game_state_ctrl #(
        .c_START_LIVES(LIVES), .c_DEATH_CYCLES(DEATH), .c_FLASH_DIV(FDIV),
        .c_PADS_PER_LEVEL(PADS), .c_WIN_SCORE(WINSC)
    ) dut (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_Start(start), .i_Collided(collided),
        .i_Drowned(drowned), .i_Score(score), .o_Game_Active(active), .o_State(state),
        .o_Lives(lives), .o_Level(level), .o_Death_Flash(flash), .o_Score_Clr(clr)
    );

    // Second instance with an unreachable win score so the level sweep can run to 45.
    game_state_ctrl #(
        .c_START_LIVES(LIVES), .c_DEATH_CYCLES(DEATH), .c_FLASH_DIV(FDIV),
        .c_PADS_PER_LEVEL(PADS), .c_WIN_SCORE(127)
    ) dut_sweep (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_Start(start), .i_Collided(1'b0),
        .i_Drowned(1'b0), .i_Score(score2), .o_Game_Active(active2), .o_State(state2),
        .o_Lives(lives2), .o_Level(level2), .o_Death_Flash(flash2), .o_Score_Clr(clr2)
    );

    typedef struct {
        logic       s, c, d;
        logic [6:0] sc;
        logic [2:0] st;
        logic [1:0] lv;
        logic [2:0] lvl;
        logic       act, fl, cl;
    } vec_t;
    vec_t vq[$];

    // Reference model state: plain integers and a start-level history.
    int m_st, m_lives, m_level, m_t, m_clr;
    bit sh[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input int s, c, d, sc, st, lv, lvl, act, fl, cl);
        vec_t v;
        v.s = s[0]; v.c = c[0]; v.d = d[0]; v.sc = 7'(sc);
        v.st = 3'(st); v.lv = 2'(lv); v.lvl = 3'(lvl);
        v.act = act[0]; v.fl = fl[0]; v.cl = cl[0];
        vq.push_back(v);
    endtask

    task automatic wait_state(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (state != 3'(target) && n < budget) begin
            step();
            n++;
        end
        chk(name, state, target);
    endtask

    task automatic pulse_start(input int target, input string name);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_state(target, 6, name);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0; collided = 1'b0; drowned = 1'b0; score = '0; score2 = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic model_step(input bit s, input bit c, input bit d, input int sc);
        bit evt;
        sh.push_back(s);
        if (sh.size() > 4) void'(sh.pop_front());
        // Synchroniser latency: the edge seen now is the one applied two and three cycles back.
        evt = sh[1] && !sh[0];
        m_clr = 0;
        case (m_st)
            0: if (evt) begin m_st = 1; m_lives = LIVES; m_level = 0; m_clr = 1; end
            1: begin
                m_level = (sc / PADS > 7) ? 7 : sc / PADS;
                if (sc >= WINSC) m_st = 4;
                else if (c || d) begin
                    m_st = 2; m_t = 0;
                    m_lives = (m_lives > 0) ? m_lives - 1 : 0;
                end
            end
            2: if (m_t == DEATH - 1) m_st = (m_lives == 0) ? 3 : 1;
               else m_t++;
            default: if (evt) m_st = 0;
        endcase
    endtask

    function automatic logic [10:0] model_outs();
        bit fl;
        fl = (m_st == 2) && ((m_t / FDIV) % 2 == 0);
        return {3'(m_st), 2'(m_lives), 3'(m_level), m_st == 1, fl, m_clr[0]};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        bit ok;
        logic [10:0] exp;
        bit rs, rc, rd;
        int rsc;

        // Reset values
        do_reset();
        rst_n = 1'b0;
        step();
        chk("reset_outs", outs, 0);
        rst_n = 1'b1;

        // Vector table: start, hit/blink timing, win priority, restart through IDLE
        add(1,0,0,0,  0,0,0,0,0,0);
        add(1,0,0,0,  0,0,0,0,0,0);
        add(1,0,0,0,  1,3,0,1,0,1);
        add(0,0,0,0,  1,3,0,1,0,0);
        add(0,1,0,0,  2,2,0,0,1,0);
        add(0,0,0,0,  2,2,0,0,1,0);
        add(0,0,0,0,  2,2,0,0,0,0);
        add(0,0,0,0,  2,2,0,0,0,0);
        add(0,0,0,0,  2,2,0,0,1,0);
        add(0,0,0,0,  2,2,0,0,1,0);
        add(0,0,0,0,  2,2,0,0,0,0);
        add(0,0,0,0,  2,2,0,0,0,0);
        add(0,0,0,0,  1,2,0,1,0,0);
        add(0,0,0,12, 1,2,2,1,0,0);
        add(0,1,0,20, 4,2,4,0,0,0);
        add(1,0,0,0,  4,2,4,0,0,0);
        add(1,0,0,0,  4,2,4,0,0,0);
        add(0,0,0,0,  0,2,4,0,0,0);
        add(1,0,0,0,  0,2,4,0,0,0);
        add(1,0,0,0,  0,2,4,0,0,0);
        add(0,0,0,0,  1,3,0,1,0,1);
        foreach (vq[i]) begin
            start = vq[i].s; collided = vq[i].c; drowned = vq[i].d; score = vq[i].sc;
            step();
            chk($sformatf("vec[%0d]", i), outs,
                {vq[i].st, vq[i].lv, vq[i].lvl, vq[i].act, vq[i].fl, vq[i].cl});
        end
        start = 1'b0; collided = 1'b0; score = '0;

        // Drowned held high: three deaths, no underflow, then GAME_OVER
        drowned = 1'b1;
        for (int h = 0; h < 3; h++) begin
            step();
            chk($sformatf("drown_enter[%0d]", h), {state, lives}, {3'd2, 2'(2 - h)});
            repeat (DEATH) step();
            chk($sformatf("drown_exit[%0d]", h), state, (h == 2) ? 3 : 1);
        end
        repeat (3) step();
        chk("game_over_hold", {state, lives}, {3'd3, 2'd0});
        drowned = 1'b0;

        // Chattering start pulse shorter than a clock: exactly one event
        #5 start = 1'b1;
        #2 start = 1'b0;
        #1 start = 1'b1;
        #4 start = 1'b0;
        repeat (6) step();
        chk("bounce_one_event", state, 0);
        pulse_start(1, "restart_play");
        chk("restart_lives", lives, LIVES);

        // Start toggling in PLAYING and DYING is ignored
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            start = ~start;
            step();
            if (state != 3'd1) ok = 1'b0;
        end
        chk("toggle_in_playing", ok, 1);
        start = 1'b0;
        collided = 1'b1;
        step();
        collided = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < DEATH; i++) begin
            start = ~start;
            step();
            if (state != ((i == DEATH - 1) ? 3'd1 : 3'd2)) ok = 1'b0;
        end
        chk("toggle_in_dying", ok, 1);
        start = 1'b0;
        repeat (4) step();
        chk("after_toggle", {state, lives}, {3'd1, 2'd2});

        // Reset in the middle of DYING
        collided = 1'b1;
        step();
        collided = 1'b0;
        repeat (3) step();
        chk("mid_dying_state", state, 2);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outs", outs, 0);
        step();
        rst_n = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (outs != 11'd0) ok = 1'b0;
        end
        chk("idle_after_reset", ok, 1);
        pulse_start(1, "play_after_reset");

        // Level sweep on the instance that cannot win
        do_reset();
        pulse_start(1, "sweep_start");
        chk("sweep_inst_playing", state2, 1);
        for (int s = 0; s <= 45; s++) begin
            score2 = 7'(s);
            step();
            chk($sformatf("level[%0d]", s), {state2, level2}, {3'd1, 3'((s / PADS > 7) ? 7 : s / PADS)});
        end
        score2 = '0;

        // Random stimulus against the reference model
        do_reset();
        m_st = 0; m_lives = 0; m_level = 0; m_t = 0; m_clr = 0;
        sh.delete();
        repeat (4) sh.push_back(1'b0);
        rs = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) rs = ~rs;
            rc  = ($urandom_range(0, 15) == 0);
            rd  = ($urandom_range(0, 19) == 0);
            rsc = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 30)) : int'($urandom_range(0, 19));
            start = rs; collided = rc; drowned = rd; score = 7'(rsc);
            model_step(rs, rc, rd, rsc);
            exp = model_outs();
            step();
            chk($sformatf("rand[%0d]", i), outs, exp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
